// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM encoding,
// access-size codes and read/write encoding.
package ece429_mem_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_F = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_e;

    localparam logic [1:0] SIZE_WORD = 2'b11;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b01;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Both 01 and 00 mean byte; the memory port always sees the canonical code.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        case (sz)
            SIZE_WORD: norm_size = SIZE_WORD;
            SIZE_HALF: norm_size = SIZE_HALF;
            default:   norm_size = SIZE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and shared-memory-port signals. The arbiter uses the
// master modport; requesters and the memory model use the slave modport.
interface mem_port_arbiter_if;
    import ece429_mem_pkg::*;

    logic              f_req_in;
    logic [ADDR_W-1:0] f_addr_in;
    logic [1:0]        f_access_size_in;
    logic              f_stall_out;
    logic              f_valid_out;
    logic [DATA_W-1:0] f_data_out;

    logic              d_req_in;
    logic              d_rw_in;
    logic [ADDR_W-1:0] d_addr_in;
    logic [DATA_W-1:0] d_wdata_in;
    logic [1:0]        d_access_size_in;
    logic              d_stall_out;
    logic              d_valid_out;
    logic [DATA_W-1:0] d_rdata_out;

    logic              mem_en_out;
    logic              mem_rw_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic [1:0]        mem_access_size_out;
    logic              mem_ready_in;
    logic [DATA_W-1:0] mem_rdata_in;

    modport master (
        input  f_req_in, f_addr_in, f_access_size_in,
        output f_stall_out, f_valid_out, f_data_out,
        input  d_req_in, d_rw_in, d_addr_in, d_wdata_in, d_access_size_in,
        output d_stall_out, d_valid_out, d_rdata_out,
        output mem_en_out, mem_rw_out, mem_addr_out, mem_wdata_out, mem_access_size_out,
        input  mem_ready_in, mem_rdata_in
    );

    modport slave (
        output f_req_in, f_addr_in, f_access_size_in,
        input  f_stall_out, f_valid_out, f_data_out,
        output d_req_in, d_rw_in, d_addr_in, d_wdata_in, d_access_size_in,
        input  d_stall_out, d_valid_out, d_rdata_out,
        input  mem_en_out, mem_rw_out, mem_addr_out, mem_wdata_out, mem_access_size_out,
        output mem_ready_in, mem_rdata_in
    );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Counts data grants that happen while fetch is waiting; saturates at limit.
module mem_arb_starve_ctr
    import ece429_mem_pkg::*;
(
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                inc,
    input  logic                clr,
    input  logic [STARVE_W-1:0] limit,
    output logic                sat
);

    logic [STARVE_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sat = (count_q >= limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one memory port, one
// access outstanding at a time; data has priority unless fetch is starved.
module mem_port_arbiter
    import ece429_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk_in,
    input  logic               reset_in,
    mem_port_arbiter_if.master bus
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] f_data_q, f_data_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              f_valid_q, f_valid_d;
    logic              d_valid_q, d_valid_d;

    logic f_elig, d_elig;
    logic grant_f, grant_d;
    logic starve_inc, starve_clr, starve_sat;

    // A requester whose completion pulse is showing cannot be re-granted yet.
    assign f_elig = bus.f_req_in & ~f_valid_q;
    assign d_elig = bus.d_req_in & ~d_valid_q;

    mem_arb_starve_ctr u_starve_ctr (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (LIMIT_C),
        .sat      (starve_sat)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        size_d     = size_q;
        f_data_d   = f_data_q;
        d_rdata_d  = d_rdata_q;
        f_valid_d  = 1'b0;
        d_valid_d  = 1'b0;
        grant_f    = 1'b0;
        grant_d    = 1'b0;
        starve_inc = 1'b0;
        starve_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_f = f_elig & (~d_elig | starve_sat);
                grant_d = d_elig & ~grant_f;
                if (grant_f) begin
                    state_d = ST_BUSY_F;
                    addr_d  = bus.f_addr_in;
                    rw_d    = RW_READ;
                    size_d  = norm_size(bus.f_access_size_in);
                end else if (grant_d) begin
                    state_d = ST_BUSY_D;
                    addr_d  = bus.d_addr_in;
                    rw_d    = bus.d_rw_in;
                    wdata_d = bus.d_wdata_in;
                    size_d  = norm_size(bus.d_access_size_in);
                end
                starve_inc = grant_d & bus.f_req_in;
                starve_clr = grant_f | ((grant_f | grant_d) & ~bus.f_req_in);
            end
            ST_BUSY_F: begin
                if (bus.mem_ready_in) begin
                    f_data_d  = bus.mem_rdata_in;
                    f_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_BUSY_D: begin
                if (bus.mem_ready_in) begin
                    if (rw_q == RW_READ) begin
                        d_rdata_d = bus.mem_rdata_in;
                    end
                    d_valid_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rw_q      <= RW_READ;
            size_q    <= '0;
            f_data_q  <= '0;
            d_rdata_q <= '0;
            f_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            f_data_q  <= f_data_d;
            d_rdata_q <= d_rdata_d;
            f_valid_q <= f_valid_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign bus.mem_en_out          = (state_q != ST_IDLE);
    assign bus.mem_rw_out          = rw_q;
    assign bus.mem_addr_out        = addr_q;
    assign bus.mem_wdata_out       = wdata_q;
    assign bus.mem_access_size_out = size_q;

    assign bus.f_stall_out = bus.f_req_in & ~f_valid_q;
    assign bus.f_valid_out = f_valid_q;
    assign bus.f_data_out  = f_data_q;
    assign bus.d_stall_out = bus.d_req_in & ~d_valid_q;
    assign bus.d_valid_out = d_valid_q;
    assign bus.d_rdata_out = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with STARVE_LIMIT = 4.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_in   (clk),
        .reset_in (rst),
        .bus      (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                  = 1'b1;
        bus.f_req_in         = 1'b0;
        bus.f_addr_in        = '0;
        bus.f_access_size_in = 2'b11;
        bus.d_req_in         = 1'b0;
        bus.d_rw_in          = 1'b0;
        bus.d_addr_in        = '0;
        bus.d_wdata_in       = '0;
        bus.d_access_size_in = 2'b11;
        bus.mem_ready_in     = 1'b0;
        bus.mem_rdata_in     = '0;

        step();
        step();
        chk("rst_mem_en",  bus.mem_en_out, 0);
        chk("rst_mem_rw",  bus.mem_rw_out, 0);
        chk("rst_f_valid", bus.f_valid_out, 0);
        chk("rst_d_valid", bus.d_valid_out, 0);
        chk("rst_addr",    bus.mem_addr_out, 0);
        chk("rst_f_data",  bus.f_data_out, 0);
        chk("rst_d_rdata", bus.d_rdata_out, 0);
        rst = 1'b0;

        // mem_ready with nothing pending
        bus.mem_ready_in = 1'b1;
        step();
        chk("idle_ready_en", bus.mem_en_out, 0);
        chk("idle_ready_fv", bus.f_valid_out, 0);
        chk("idle_ready_dv", bus.d_valid_out, 0);
        bus.mem_ready_in = 1'b0;

        // fetch only, ready in second busy cycle
        bus.f_req_in  = 1'b1;
        bus.f_addr_in = 32'h8002_0000;
        step();
        chk("f1_en",    bus.mem_en_out, 1);
        chk("f1_addr",  bus.mem_addr_out, 32'h8002_0000);
        chk("f1_rw",    bus.mem_rw_out, 0);
        chk("f1_size",  bus.mem_access_size_out, 2'b11);
        chk("f1_stall", bus.f_stall_out, 1);
        step();
        chk("f1_busy2", bus.mem_en_out, 1);
        chk("f1_novld", bus.f_valid_out, 0);
        bus.mem_ready_in = 1'b1;
        bus.mem_rdata_in = 32'h1300_0093;
        step();
        chk("f1_valid",   bus.f_valid_out, 1);
        chk("f1_data",    bus.f_data_out, 32'h1300_0093);
        chk("f1_unstall", bus.f_stall_out, 0);
        chk("f1_idle",    bus.mem_en_out, 0);
        bus.f_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();
        chk("f1_pulse_end", bus.f_valid_out, 0);

        // data read, half-word, minimum latency
        bus.d_req_in         = 1'b1;
        bus.d_rw_in          = 1'b0;
        bus.d_addr_in        = 32'h8002_0010;
        bus.d_access_size_in = 2'b10;
        bus.mem_ready_in     = 1'b1;
        bus.mem_rdata_in     = 32'hA5A5_0001;
        step();
        chk("dr_en",   bus.mem_en_out, 1);
        chk("dr_size", bus.mem_access_size_out, 2'b10);
        chk("dr_rw",   bus.mem_rw_out, 0);
        step();
        chk("dr_valid", bus.d_valid_out, 1);
        chk("dr_data",  bus.d_rdata_out, 32'hA5A5_0001);
        bus.d_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();
        chk("dr_pulse_end", bus.d_valid_out, 0);

        // data write, byte size code 00
        bus.d_req_in         = 1'b1;
        bus.d_rw_in          = 1'b1;
        bus.d_addr_in        = 32'h8002_0100;
        bus.d_wdata_in       = 32'hDEAD_BEEF;
        bus.d_access_size_in = 2'b00;
        step();
        chk("dw_rw",    bus.mem_rw_out, 1);
        chk("dw_wdata", bus.mem_wdata_out, 32'hDEAD_BEEF);
        chk("dw_addr",  bus.mem_addr_out, 32'h8002_0100);
        chk("dw_size",  bus.mem_access_size_out, 2'b01);
        bus.mem_ready_in = 1'b1;
        bus.mem_rdata_in = 32'h5555_5555;
        step();
        chk("dw_valid", bus.d_valid_out, 1);
        chk("dw_rdata_kept", bus.d_rdata_out, 32'hA5A5_0001);
        bus.d_req_in     = 1'b0;
        bus.d_rw_in      = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();

        // simultaneous fetch and data: data first
        bus.f_req_in         = 1'b1;
        bus.f_addr_in        = 32'h8002_0004;
        bus.d_req_in         = 1'b1;
        bus.d_addr_in        = 32'h8002_0200;
        bus.d_access_size_in = 2'b11;
        step();
        chk("both_addr",    bus.mem_addr_out, 32'h8002_0200);
        chk("both_fstall",  bus.f_stall_out, 1);
        chk("both_dstall",  bus.d_stall_out, 1);
        bus.mem_ready_in = 1'b1;
        bus.mem_rdata_in = 32'h1111_2222;
        step();
        chk("both_dvalid",  bus.d_valid_out, 1);
        chk("both_ddata",   bus.d_rdata_out, 32'h1111_2222);
        chk("both_fstall2", bus.f_stall_out, 1);
        bus.d_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();
        chk("both_f_addr", bus.mem_addr_out, 32'h8002_0004);
        chk("both_f_rw",   bus.mem_rw_out, 0);
        chk("both_fstall3", bus.f_stall_out, 1);
        bus.mem_ready_in = 1'b1;
        bus.mem_rdata_in = 32'h3333_4444;
        step();
        chk("both_fvalid", bus.f_valid_out, 1);
        chk("both_fdata",  bus.f_data_out, 32'h3333_4444);
        bus.f_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();

        // starvation: fetch present at each data grant, four data wins
        bus.f_addr_in = 32'h8002_0008;
        bus.d_req_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.f_req_in  = 1'b1;
            bus.d_addr_in = 32'h8002_0300 + 32'(i * 4);
            step();
            chk("starve_dgrant", bus.mem_addr_out, 32'h8002_0300 + 32'(i * 4));
            bus.mem_ready_in = 1'b1;
            bus.mem_rdata_in = 32'(i);
            step();
            chk("starve_dvalid", bus.d_valid_out, 1);
            bus.f_req_in     = 1'b0;
            bus.mem_ready_in = 1'b0;
            step();
            chk("starve_gap", bus.mem_en_out, 0);
        end
        bus.f_req_in  = 1'b1;
        bus.d_addr_in = 32'h8002_0320;
        step();
        chk("starve_fgrant", bus.mem_addr_out, 32'h8002_0008);
        chk("starve_f_rw",   bus.mem_rw_out, 0);
        chk("starve_dstall", bus.d_stall_out, 1);
        bus.mem_ready_in = 1'b1;
        bus.mem_rdata_in = 32'hCAFE_0005;
        step();
        chk("starve_fvalid", bus.f_valid_out, 1);
        chk("starve_fdata",  bus.f_data_out, 32'hCAFE_0005);
        bus.f_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();
        chk("starve_after_d", bus.mem_addr_out, 32'h8002_0320);
        bus.mem_ready_in = 1'b1;
        step();
        chk("starve_after_dv", bus.d_valid_out, 1);
        bus.d_req_in     = 1'b0;
        bus.mem_ready_in = 1'b0;
        step();

        // reset during a data access
        bus.d_req_in  = 1'b1;
        bus.d_rw_in   = 1'b0;
        bus.d_addr_in = 32'h8002_0400;
        step();
        chk("rstmid_busy", bus.mem_en_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_en",   bus.mem_en_out, 0);
        chk("rstmid_addr", bus.mem_addr_out, 0);
        chk("rstmid_dv",   bus.d_valid_out, 0);
        #2 rst = 1'b0;
        bus.mem_ready_in = 1'b1;
        step();
        chk("rstmid_regrant", bus.mem_addr_out, 32'h8002_0400);
        chk("rstmid_en2",     bus.mem_en_out, 1);
        chk("rstmid_nodv",    bus.d_valid_out, 0);
        // withdraw the request mid-access; completion still reported
        bus.d_req_in     = 1'b0;
        bus.mem_rdata_in = 32'h7777_8888;
        step();
        chk("withdraw_dv",     bus.d_valid_out, 1);
        chk("withdraw_data",   bus.d_rdata_out, 32'h7777_8888);
        chk("withdraw_dstall", bus.d_stall_out, 0);
        bus.mem_ready_in = 1'b0;
        step();
        chk("final_idle", bus.mem_en_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, 4, max consecutive data grants while fetch waits (range 1..15).
REQ-002 clk_in  input  1  single clock; all state updates on posedge.
REQ-003 reset_in  input  1  asynchronous, active-high reset.
REQ-004 f_req_in  input  1  fetch read request; held high until f_valid_out.
REQ-005 f_addr_in  input  32  fetch address (PC).
REQ-006 f_access_size_in  input  2  11 word, 10 half-word, 01/00 byte.
REQ-007 f_stall_out  output  1  fetch must hold PC.
REQ-008 f_valid_out  output  1  one-cycle pulse: f_data_out valid.
REQ-009 f_data_out  output  32  fetched instruction word.
REQ-010 d_req_in / d_rw_in / d_addr_in / d_wdata_in / d_access_size_in  input  1/1/32/32/2  data request; rw 0 read, 1 write.
REQ-011 d_stall_out / d_valid_out / d_rdata_out  output  1/1/32  data stall, completion pulse, read data.
REQ-012 mem_en_out / mem_rw_out / mem_addr_out / mem_wdata_out / mem_access_size_out  output  1/1/32/32/2  shared memory port.
REQ-013 mem_ready_in / mem_rdata_in  input  1/32  memory completion and read data.

Function
REQ-014 FSM states IDLE, BUSY_F, BUSY_D; one outstanding access at a time.
REQ-015 IDLE: at posedge with any eligible request, grant per REQ-017, latch addr/rw/wdata/size into port registers, enter BUSY_F or BUSY_D.
REQ-016 A request is ineligible in the cycle its own valid_out is high.
REQ-017 Priority: data over fetch, except fetch wins when starve count == STARVE_LIMIT and f_req_in high.
REQ-018 Starve count: +1 on each data grant while f_req_in high (saturates at STARVE_LIMIT); cleared on fetch grant or when f_req_in low at a grant.
REQ-019 BUSY_x: mem_en_out = 1, port registers stable; fetch grant forces mem_rw_out = 0.
REQ-020 BUSY_x with mem_ready_in = 1 at posedge: capture mem_rdata_in (fetch, or data read only), pulse x_valid_out next cycle, return to IDLE.
REQ-021 Data write completion pulses d_valid_out; d_rdata_out keeps its previous value.
REQ-022 x_stall_out = x_req_in AND NOT x_valid_out (combinational).
REQ-023 Minimum latency: request sampled at edge N, earliest valid_out in cycle after edge N+1 (ready same cycle as first BUSY cycle).
REQ-024 Simultaneous new requests in IDLE: exactly one grant; loser stays stalled, arbitrated at next IDLE edge.
REQ-025 mem_ready_in in IDLE is ignored.
REQ-026 Request withdrawn mid-access: access completes, valid_out still pulses.

Reset
REQ-027 On reset_in high: state IDLE; mem_en_out, mem_rw_out, f_valid_out, d_valid_out = 0; all data/addr registers = 0; starve count = 0.
REQ-028 Reset mid-access aborts it; no valid_out pulses for the aborted access.

Structure
REQ-029 Shared package ece429_mem_pkg holds FSM state encoding, access-size constants (WORD 11, HALF 10, BYTE 01), and RW_READ/RW_WRITE.
REQ-030 Starvation counter is a sub-module mem_arb_starve_ctr (inc, clr, sat, limit); the rest stays flat.

Verification
REQ-031 Fetch only, f_addr_in 0x80020000, ready after 2 BUSY cycles -> mem_addr_out 0x80020000, mem_rw_out 0, f_valid_out one cycle with f_data_out = mem_rdata_in.
REQ-032 Both requests in the same cycle, no starvation -> data granted first, f_stall_out high until fetch completes next.
REQ-033 Data requests back-to-back, fetch held, STARVE_LIMIT 4 -> after 4 data grants the 5th grant goes to fetch.
REQ-034 Data write 0xDEADBEEF to 0x80020100 -> mem_rw_out 1, mem_wdata_out 0xDEADBEEF, d_valid_out pulses, d_rdata_out unchanged.
REQ-035 reset_in asserted in BUSY_D -> immediately IDLE, mem_en_out 0, no d_valid_out; next request is arbitrated normally.
